hazard_ctrl: RTL and testbench
==============================

HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 SHALL have parameter REDIRECT_BUBBLES, default 1: extra cycles flush_if is held after a redirect (fetch latency, 0..3).
REQ-002 SHALL have parameter DMEM_TIMEOUT, default 255: maximum data-memory wait cycles before err_timeout (8-bit).
REQ-003 SHALL have port clk  input  1  single clock, rising edge; reset is asynchronous and active-high.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port id_rs1  input  5  ID source register 1; 0 when the instruction does not use it.
REQ-006 SHALL have port id_rs2  input  5  ID source register 2; 0 when the instruction does not use it.
REQ-007 SHALL have port ex_rd  input  5  EX destination register.
REQ-008 SHALL have port ex_is_load  input  1  EX holds a load.
REQ-009 SHALL have port ex_redirect  input  1  EX resolved a taken branch or jump.
REQ-010 SHALL have port imem_ready  input  1  instruction memory returns valid data this cycle.
REQ-011 SHALL have port mem_req  input  1  MEM stage issues a data-memory access.
REQ-012 SHALL have port dmem_ready  input  1  data memory completes the access this cycle.
REQ-013 SHALL have ports stall_pc, stall_if, stall_sub_if, stall_id, stall_ex, stall_mem  output  1 each  hold that stage register.
REQ-014 SHALL have ports flush_if, flush_id, flush_ex, flush_mem, flush_sub_mem  output  1 each  load a bubble into that stage register.
REQ-015 SHALL have port err_timeout  output  1  sticky data-memory timeout flag.

Function
REQ-016 SHALL implement registered FSM states RUN, REDIRECT and DMEM_WAIT; all stall and flush outputs SHALL be combinational from state and current inputs.
REQ-017 SHALL define load_use = ex_is_load && ex_rd!=0 && (id_rs1==ex_rd || id_rs2==ex_rd).
REQ-018 SHALL apply the following priority, highest first: data wait (mem_req && !dmem_ready, or state DMEM_WAIT) > ex_redirect > REDIRECT state > load_use > !imem_ready.
REQ-019 SHALL, on data wait, assert all six stall outputs and flush_sub_mem, with no other flush asserted; RUN->DMEM_WAIT on mem_req && !dmem_ready.
REQ-020 SHALL, in DMEM_WAIT, exit to RUN in the cycle dmem_ready=1; that cycle SHALL still stall and the pipeline SHALL advance on the next edge.
REQ-021 SHALL count DMEM_WAIT cycles in an 8-bit counter; on reaching DMEM_TIMEOUT it SHALL set err_timeout, return to RUN and assert flush_mem for one cycle. The counter SHALL clear on entry to DMEM_WAIT.
REQ-022 SHALL, on ex_redirect in RUN, assert flush_if and flush_id with no stalls, and enter REDIRECT if REDIRECT_BUBBLES>0.
REQ-023 SHALL, in REDIRECT, assert flush_if only, for exactly REDIRECT_BUBBLES cycles, then return to RUN; a new ex_redirect in this state SHALL restart the count.
REQ-024 SHALL, on load_use, assert stall_pc, stall_if, stall_sub_if, stall_id and flush_ex for one cycle; it repeats naturally while the condition holds.
REQ-025 SHALL, on !imem_ready with no higher event, assert stall_pc, stall_if, stall_sub_if and flush_id.
REQ-026 SHALL hold a redirect arriving during data wait, since EX is stalled, and act on it in the first non-wait cycle.
REQ-027 SHALL treat ex_rd=0 as never hazardous.

Reset
REQ-028 SHALL, while rst=1, force state RUN, wait counter 0, REDIRECT counter 0 and err_timeout 0; all flush outputs SHALL be 1 and all stall outputs 0.
REQ-029 SHALL, on reset asserted mid-wait or mid-redirect, abandon the sequence immediately with no residual flush after release.

Structure
REQ-030 SHALL place the FSM state enum and register-index width constant in the shared pipeline package.
REQ-031 SHALL be a single module without sub-modules; the priority encoder is inline.

Verification
REQ-032 Load-use: ex_is_load=1, ex_rd=5, id_rs2=5 for one cycle -> stall_pc/if/sub_if/id=1 and flush_ex=1 that cycle only.
REQ-033 Redirect with REDIRECT_BUBBLES=2: ex_redirect pulse -> flush_if/id cycle 0, then flush_if alone cycles 1-2, then all outputs 0.
REQ-034 Data wait: mem_req=1, dmem_ready=0 for 3 cycles then 1 -> all stalls plus flush_sub_mem for 4 cycles, then released.
REQ-035 Timeout with DMEM_TIMEOUT=4: dmem_ready held 0 -> err_timeout=1 after 4 wait cycles, one flush_mem pulse, state RUN; err_timeout stays 1 until rst.
REQ-036 Collisions: ex_redirect together with load_use -> redirect response only; ex_redirect during data wait -> no flush until dmem_ready, then flush_if/id.
REQ-037 Reset mid-DMEM_WAIT -> all flush=1, stall=0 while rst=1; idle outputs all 0 after release.

Source files
------------

// File: rtl/hazard_ctrl_pkg.sv
// Shared pipeline definitions for the hazard controller: register-index width,
// counter widths, controller state encoding and the load-use test.
package hazard_ctrl_pkg;

    localparam int REG_IDX_W    = 5;
    localparam int WAIT_CNT_W   = 8;
    localparam int BUBBLE_CNT_W = 2;

    typedef enum logic [1:0] {
        ST_RUN       = 2'd0,
        ST_REDIRECT  = 2'd1,
        ST_DMEM_WAIT = 2'd2
    } hazState_t;

    // x0 is hardwired zero, so a load targeting it can never create a hazard.
    function automatic logic isLoadUse(
        input logic                 isLoad,
        input logic [REG_IDX_W-1:0] rd,
        input logic [REG_IDX_W-1:0] rs1,
        input logic [REG_IDX_W-1:0] rs2
    );
        return isLoad && (rd != '0) && ((rs1 == rd) || (rs2 == rd));
    endfunction

endpackage

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: prioritises data-memory waits, control redirects,
// load-use hazards and fetch stalls into per-stage stall/flush controls.
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int REDIRECT_BUBBLES = 1,
    parameter int DMEM_TIMEOUT     = 255
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [REG_IDX_W-1:0] id_rs1,
    input  logic [REG_IDX_W-1:0] id_rs2,
    input  logic [REG_IDX_W-1:0] ex_rd,
    input  logic                 ex_is_load,
    input  logic                 ex_redirect,
    input  logic                 imem_ready,
    input  logic                 mem_req,
    input  logic                 dmem_ready,
    output logic                 stall_pc,
    output logic                 stall_if,
    output logic                 stall_sub_if,
    output logic                 stall_id,
    output logic                 stall_ex,
    output logic                 stall_mem,
    output logic                 flush_if,
    output logic                 flush_id,
    output logic                 flush_ex,
    output logic                 flush_mem,
    output logic                 flush_sub_mem,
    output logic                 err_timeout
);

    localparam logic [WAIT_CNT_W-1:0]   TIMEOUT_LAST = WAIT_CNT_W'(DMEM_TIMEOUT - 1);
    localparam logic [BUBBLE_CNT_W-1:0] BUBBLE_LAST  = BUBBLE_CNT_W'(REDIRECT_BUBBLES - 1);

    hazState_t               r_state;
    hazState_t               w_stateNext;
    logic [WAIT_CNT_W-1:0]   r_waitCnt;
    logic [WAIT_CNT_W-1:0]   w_waitCntNext;
    logic [BUBBLE_CNT_W-1:0] r_redirCnt;
    logic [BUBBLE_CNT_W-1:0] w_redirCntNext;
    logic                    r_redirPend;
    logic                    w_redirPendNext;
    logic                    r_errTimeout;
    logic                    w_errTimeoutNext;

    logic w_loadUse;
    logic w_inWait;
    logic w_dataWait;
    logic w_timeout;
    logic w_redirect;

    assign w_loadUse   = isLoadUse(ex_is_load, ex_rd, id_rs1, id_rs2);
    assign w_inWait    = (r_state == ST_DMEM_WAIT);
    assign w_dataWait  = w_inWait || (mem_req && !dmem_ready);
    assign w_timeout   = w_inWait && !dmem_ready && (r_waitCnt == TIMEOUT_LAST);
    // A redirect seen while EX was frozen is remembered until the wait ends.
    assign w_redirect  = ex_redirect || r_redirPend;
    assign err_timeout = r_errTimeout;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= ST_RUN;
            r_waitCnt    <= '0;
            r_redirCnt   <= '0;
            r_redirPend  <= 1'b0;
            r_errTimeout <= 1'b0;
        end else begin
            r_state      <= w_stateNext;
            r_waitCnt    <= w_waitCntNext;
            r_redirCnt   <= w_redirCntNext;
            r_redirPend  <= w_redirPendNext;
            r_errTimeout <= w_errTimeoutNext;
        end
    end

    always_comb begin
        w_stateNext      = r_state;
        w_waitCntNext    = r_waitCnt;
        w_redirCntNext   = r_redirCnt;
        w_redirPendNext  = r_redirPend;
        w_errTimeoutNext = r_errTimeout;
        if (w_dataWait) begin
            // Remaining fetch bubbles are replayed as a redirect once the wait ends.
            if (ex_redirect || (r_state == ST_REDIRECT)) begin
                w_redirPendNext = 1'b1;
            end
            if (w_inWait) begin
                if (dmem_ready) begin
                    w_stateNext = ST_RUN;
                end else if (w_timeout) begin
                    w_stateNext      = ST_RUN;
                    w_errTimeoutNext = 1'b1;
                end else begin
                    w_waitCntNext = r_waitCnt + 1'b1;
                end
            end else begin
                w_stateNext   = ST_DMEM_WAIT;
                w_waitCntNext = '0;
            end
        end else if (w_redirect) begin
            w_redirPendNext = 1'b0;
            if (REDIRECT_BUBBLES > 0) begin
                w_stateNext    = ST_REDIRECT;
                w_redirCntNext = BUBBLE_LAST;
            end else begin
                w_stateNext = ST_RUN;
            end
        end else if (r_state == ST_REDIRECT) begin
            if (r_redirCnt == '0) begin
                w_stateNext = ST_RUN;
            end else begin
                w_redirCntNext = r_redirCnt - 1'b1;
            end
        end
    end

    always_comb begin
        stall_pc      = 1'b0;
        stall_if      = 1'b0;
        stall_sub_if  = 1'b0;
        stall_id      = 1'b0;
        stall_ex      = 1'b0;
        stall_mem     = 1'b0;
        flush_if      = 1'b0;
        flush_id      = 1'b0;
        flush_ex      = 1'b0;
        flush_mem     = 1'b0;
        flush_sub_mem = 1'b0;
        if (rst) begin
            flush_if      = 1'b1;
            flush_id      = 1'b1;
            flush_ex      = 1'b1;
            flush_mem     = 1'b1;
            flush_sub_mem = 1'b1;
        end else if (w_dataWait) begin
            stall_pc     = 1'b1;
            stall_if     = 1'b1;
            stall_sub_if = 1'b1;
            stall_id     = 1'b1;
            stall_ex     = 1'b1;
            // On timeout the hung access is dropped by bubbling MEM instead of holding it.
            if (w_timeout) begin
                flush_mem = 1'b1;
            end else begin
                stall_mem     = 1'b1;
                flush_sub_mem = 1'b1;
            end
        end else if (w_redirect) begin
            flush_if = 1'b1;
            flush_id = 1'b1;
        end else if (r_state == ST_REDIRECT) begin
            flush_if = 1'b1;
        end else if (w_loadUse) begin
            stall_pc     = 1'b1;
            stall_if     = 1'b1;
            stall_sub_if = 1'b1;
            stall_id     = 1'b1;
            flush_ex     = 1'b1;
        end else if (!imem_ready) begin
            stall_pc     = 1'b1;
            stall_if     = 1'b1;
            stall_sub_if = 1'b1;
            flush_id     = 1'b1;
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed hazard scenarios followed by
// randomized traffic, all compared against a cycle-level behavioural model.
module tb_hazard_ctrl;

    localparam int BUBBLES = 2;
    localparam int TIMEOUT = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [4:0] id_rs1 = '0;
    logic [4:0] id_rs2 = '0;
    logic [4:0] ex_rd = '0;
    logic       ex_is_load = 1'b0;
    logic       ex_redirect = 1'b0;
    logic       imem_ready = 1'b1;
    logic       mem_req = 1'b0;
    logic       dmem_ready = 1'b1;
    logic       stall_pc, stall_if, stall_sub_if, stall_id, stall_ex, stall_mem;
    logic       flush_if, flush_id, flush_ex, flush_mem, flush_sub_mem;
    logic       err_timeout;

    int checks = 0;
    int errors = 0;

    // Model state: DMEM_WAIT cycles already spent (-1 = not waiting),
    // fetch bubbles still owed, a deferred redirect and the sticky error.
    int mWaitLen = -1;
    int mBubbles = 0;
    bit mPend    = 1'b0;
    bit mErr     = 1'b0;

    always #5 clk = ~clk;

    hazard_ctrl #(
        .REDIRECT_BUBBLES(BUBBLES),
        .DMEM_TIMEOUT    (TIMEOUT)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .id_rs1       (id_rs1),
        .id_rs2       (id_rs2),
        .ex_rd        (ex_rd),
        .ex_is_load   (ex_is_load),
        .ex_redirect  (ex_redirect),
        .imem_ready   (imem_ready),
        .mem_req      (mem_req),
        .dmem_ready   (dmem_ready),
        .stall_pc     (stall_pc),
        .stall_if     (stall_if),
        .stall_sub_if (stall_sub_if),
        .stall_id     (stall_id),
        .stall_ex     (stall_ex),
        .stall_mem    (stall_mem),
        .flush_if     (flush_if),
        .flush_id     (flush_id),
        .flush_ex     (flush_ex),
        .flush_mem    (flush_mem),
        .flush_sub_mem(flush_sub_mem),
        .err_timeout  (err_timeout)
    );

    task automatic checkOutput(input string tag, input logic [15:0] observed, input logic [15:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s got %0h expected %0h at %0t", tag, observed, expected, $time);
        end
    endtask

    // Drives one cycle of inputs, checks outputs mid-cycle, then advances the model.
    task automatic applyStimulus(input string tag, input logic rstIn, input logic [4:0] rs1, input logic [4:0] rs2,
                                 input logic [4:0] rd, input logic isLoad, input logic redir, input logic imemRdy,
                                 input logic memReq, input logic dmemRdy);
        logic [5:0] expStall;
        logic [4:0] expFlush;
        bit hazard, inWait, waiting, timedOut, redirNow;
        rst = rstIn; id_rs1 = rs1; id_rs2 = rs2; ex_rd = rd; ex_is_load = isLoad;
        ex_redirect = redir; imem_ready = imemRdy; mem_req = memReq; dmem_ready = dmemRdy;
        if (rstIn) begin
            mWaitLen = -1; mBubbles = 0; mPend = 1'b0; mErr = 1'b0;
        end
        hazard   = isLoad && (rd != 5'd0) && ((rs1 == rd) || (rs2 == rd));
        inWait   = (mWaitLen >= 0);
        waiting  = inWait || (memReq && !dmemRdy);
        timedOut = inWait && !dmemRdy && (mWaitLen + 1 == TIMEOUT);
        redirNow = redir || mPend;
        expStall = 6'b000000;
        expFlush = 5'b00000;
        if (rstIn)              expFlush = 5'b11111;
        else if (timedOut)      begin expStall = 6'b111110; expFlush = 5'b00010; end
        else if (waiting)       begin expStall = 6'b111111; expFlush = 5'b00001; end
        else if (redirNow)      expFlush = 5'b11000;
        else if (mBubbles > 0)  expFlush = 5'b10000;
        else if (hazard)        begin expStall = 6'b111100; expFlush = 5'b00100; end
        else if (!imemRdy)      begin expStall = 6'b111000; expFlush = 5'b01000; end
        @(negedge clk);
        checkOutput({tag, ":stall"}, {10'd0, stall_pc, stall_if, stall_sub_if, stall_id, stall_ex, stall_mem},
                    {10'd0, expStall});
        checkOutput({tag, ":flush"}, {11'd0, flush_if, flush_id, flush_ex, flush_mem, flush_sub_mem},
                    {11'd0, expFlush});
        checkOutput({tag, ":err"}, {15'd0, err_timeout}, {15'd0, mErr});
        if (!rstIn) begin
            if (waiting) begin
                if (redir || mBubbles > 0) mPend = 1'b1;
                mBubbles = 0;
                if (!inWait)       mWaitLen = 0;
                else if (dmemRdy)  mWaitLen = -1;
                else if (timedOut) begin mWaitLen = -1; mErr = 1'b1; end
                else               mWaitLen++;
            end else if (redirNow) begin
                mPend    = 1'b0;
                mBubbles = BUBBLES;
            end else if (mBubbles > 0) begin
                mBubbles--;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input string tag, input int n);
        for (int i = 0; i < n; i++) applyStimulus(tag, 0, 0, 0, 0, 0, 0, 1, 0, 1);
    endtask

    initial begin
        applyStimulus("reset", 1, 0, 0, 0, 0, 0, 1, 0, 1);
        applyStimulus("reset", 1, 0, 0, 0, 0, 0, 1, 0, 1);
        idle("idle", 2);

        applyStimulus("loaduse", 0, 5'd3, 5'd5, 5'd5, 1, 0, 1, 0, 1);
        idle("loaduse_after", 1);
        applyStimulus("x0_load", 0, 5'd0, 5'd0, 5'd0, 1, 0, 1, 0, 1);
        applyStimulus("imem_stall", 0, 0, 0, 0, 0, 0, 0, 0, 1);
        applyStimulus("imem_stall", 0, 0, 0, 0, 0, 0, 0, 0, 1);

        applyStimulus("redirect", 0, 0, 0, 0, 0, 1, 1, 0, 1);
        idle("redirect_bubble", 4);

        applyStimulus("redir_loaduse", 0, 5'd7, 5'd0, 5'd7, 1, 1, 1, 0, 1);
        applyStimulus("redir_bubble_lu", 0, 5'd7, 5'd0, 5'd7, 1, 0, 0, 0, 1);
        idle("redir_lu_after", 3);

        for (int i = 0; i < 3; i++) applyStimulus("dwait", 0, 0, 0, 0, 0, 0, 1, 1, 0);
        applyStimulus("dwait_done", 0, 0, 0, 0, 0, 0, 1, 1, 1);
        idle("dwait_after", 1);

        applyStimulus("redir_in_wait", 0, 0, 0, 0, 0, 1, 1, 1, 0);
        applyStimulus("redir_in_wait", 0, 0, 0, 0, 0, 1, 1, 1, 0);
        applyStimulus("redir_wait_done", 0, 0, 0, 0, 0, 1, 1, 1, 1);
        idle("redir_replayed", 4);

        for (int i = 0; i < 5; i++) applyStimulus("timeout", 0, 0, 0, 0, 0, 0, 1, 1, 0);
        idle("timeout_after", 3);

        applyStimulus("rst_wait", 0, 0, 0, 0, 0, 0, 1, 1, 0);
        applyStimulus("rst_wait", 0, 0, 0, 0, 0, 0, 1, 1, 0);
        applyStimulus("rst_wait_rst", 1, 0, 0, 0, 0, 0, 1, 1, 0);
        applyStimulus("rst_wait_rst", 1, 0, 0, 0, 0, 0, 1, 1, 0);
        idle("rst_wait_after", 3);

        applyStimulus("rst_redir", 0, 0, 0, 0, 0, 1, 1, 0, 1);
        applyStimulus("rst_redir_rst", 1, 0, 0, 0, 0, 0, 1, 0, 1);
        idle("rst_redir_after", 3);

        for (int i = 0; i < 1500; i++) begin
            logic       rRst, rLoad, rRedir, rImem, rReq, rRdy;
            logic [4:0] rRs1, rRs2, rRd;
            rRst   = ($urandom_range(0, 99) == 0);
            rRs1   = 5'($urandom_range(0, 3));
            rRs2   = 5'($urandom_range(0, 3));
            rRd    = 5'($urandom_range(0, 3));
            rLoad  = ($urandom_range(0, 2) == 0);
            rRedir = ($urandom_range(0, 7) == 0);
            rImem  = ($urandom_range(0, 4) != 0);
            rReq   = ($urandom_range(0, 3) == 0);
            rRdy   = ($urandom_range(0, 9) < 6);
            applyStimulus("random", rRst, rRs1, rRs2, rRd, rLoad, rRedir, rImem, rReq, rRdy);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
